max_pool: RTL and testbench
===========================

MAX_POOL -- requirements
Module: max_pool

Interface
REQ-001 Parameter DATA_W, default 8, width of one pixel and one pooled result.
REQ-002 Parameter NUM_WIN, default 3, number of 2x2 pooling windows per input strip.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 indata  input  4*NUM_WIN*DATA_W (96)  two pixel rows of 2*NUM_WIN pixels each; pixel p at indata[p*DATA_W +: DATA_W]; row0 = p 0..5, row1 = p 6..11.
REQ-006 result  output  NUM_WIN*DATA_W (24)  window k maximum at result[k*DATA_W +: DATA_W]; registered.
REQ-007 maxpoolingdone  output  1  one-cycle pulse; result holds a freshly completed pooling pass.

Function
REQ-008 Window k covers row0[2k], row0[2k+1], row1[2k], row1[2k+1]; its result is the maximum of those four pixels.
REQ-009 Comparison is unsigned by default; on a tie, the value is the tied maximum (no ordering dependence).
REQ-010 The block runs free without a start input through the states LOAD -> CMP1 -> CMP2 -> CMP3 -> DONE -> LOAD.
REQ-011 LOAD edge: indata is captured into an internal register; acc[k] is set to row0[2k].
REQ-012 CMP1/CMP2/CMP3 edges: acc[k] is replaced by max(acc[k], x), with x = row0[2k+1], row1[2k], row1[2k+1] respectively; all windows proceed in parallel.
REQ-013 DONE edge: result is loaded from acc, and maxpoolingdone is set to 1.
REQ-014 maxpoolingdone is cleared on the next edge (LOAD), so it is high exactly one cycle in every five.
REQ-015 Latency is 5 rising edges from indata capture to the edge that asserts maxpoolingdone and updates result.
REQ-016 Changes on indata outside the LOAD edge do not affect the pass in progress; they are taken at the next LOAD.
REQ-017 result holds its value between DONE edges.

Reset
REQ-018 While rst=1: state=LOAD, result=0, maxpoolingdone=0, and the captured-data and acc registers are 0, all without waiting for clk.
REQ-019 The first rising edge after rst deasserts is a LOAD edge; the first maxpoolingdone pulse follows the 5th edge.
REQ-020 Reset asserted mid-pass abandons that pass; result stays 0 and no done pulse is produced for it.

Configuration
REQ-021 With macro MAX_POOL_SIGNED_EN defined, pixels compare as two's-complement signed DATA_W values; without it, they compare as unsigned; nothing else changes.

Structure
REQ-022 Shared package max_pool_pkg holds DATA_W and NUM_WIN defaults, derived widths (IN_W=4*NUM_WIN*DATA_W, OUT_W=NUM_WIN*DATA_W), and the state enumeration type.
REQ-023 One sub-module, max_pool_cmp, is a combinational 2-input max of DATA_W honouring MAX_POOL_SIGNED_EN; it is instantiated NUM_WIN times.

Verification
REQ-024 All twelve pixels = 3, rst pulsed then released -> result=0x030303 with maxpoolingdone high for one cycle after the 5th edge, then every 5 cycles.
REQ-025 Pixel p = p+1 (1..12) -> result=0x0C0A08 (window0=8, window1=10, window2=12).
REQ-026 Unsigned build: window0 pixels {0x80,0x7F,0x01,0x00}, others 0 -> window0 result 0x80; with MAX_POOL_SIGNED_EN -> 0x7F.
REQ-027 indata changed during CMP2 -> the current pass reports the old data's maxima; the next pass reports the new data's maxima.
REQ-028 rst asserted during CMP2 -> result=0 and maxpoolingdone=0 immediately; after release, the full 5-cycle latency is seen again.
REQ-029 All pixels 0xFF, and separately all pixels 0x00 -> result=0xFFFFFF and 0x000000 respectively.

Source files
------------

// File: rtl/max_pool_pkg.sv
// ---------------------------------------------------------------------------
// max_pool_pkg
// Shared definitions for the 2x2 max-pooling block: default pixel width and
// window count, the derived bus widths, and the pooling sequence states.
//
// Contents:
//   DEF_DATA_W  - default width of one pixel / one pooled result
//   DEF_NUM_WIN - default number of 2x2 windows per input strip
//   IN_W        - width of the input strip bus (two rows of 2*NUM_WIN pixels)
//   OUT_W       - width of the pooled result bus (one value per window)
//   SLOTS       - pixels per window still to be compared after the load step
//   state_t     - pooling sequence LOAD -> CMP1 -> CMP2 -> CMP3 -> DONE
//
// Optional feature macro used by the files that import this package:
//   MAX_POOL_SIGNED_EN - compare pixels as two's-complement signed values
// ---------------------------------------------------------------------------
package max_pool_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_WIN = 3;

  localparam int IN_W  = 4 * DEF_NUM_WIN * DEF_DATA_W;
  localparam int OUT_W = DEF_NUM_WIN * DEF_DATA_W;

  // The first pixel of each window seeds the accumulator directly, so only
  // the remaining three need to be held for the compare steps.
  localparam int SLOTS = 3;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_CMP1 = 3'd1,
    ST_CMP2 = 3'd2,
    ST_CMP3 = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/max_pool_cmp.sv
// ---------------------------------------------------------------------------
// max_pool_cmp
// Combinational two-input maximum of DATA_W-bit pixels.
//
// Ports:
//   a - first operand (the running maximum in max_pool)
//   b - second operand (the next pixel of the window)
//   y - the larger of a and b; on a tie both are equal so either is returned
//
// Macro MAX_POOL_SIGNED_EN: when defined, a and b are compared as
// two's-complement signed values; otherwise they are compared as unsigned.
// ---------------------------------------------------------------------------
module max_pool_cmp
  import max_pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic a_ge_b;

`ifdef MAX_POOL_SIGNED_EN
  assign a_ge_b = ($signed(a) >= $signed(b));
`else
  assign a_ge_b = (a >= b);
`endif

  assign y = a_ge_b ? a : b;

endmodule

// File: rtl/max_pool.sv
// ---------------------------------------------------------------------------
// max_pool
// Free-running 2x2 max pooling over a two-row pixel strip. Every five clock
// cycles the block captures a strip, reduces each 2x2 window to its maximum
// with one comparator per window, and publishes all window maxima together
// with a one-cycle done pulse.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - asynchronous active-high reset
//   indata         - pixel p at indata[p*DATA_W +: DATA_W]; pixels
//                    0..2*NUM_WIN-1 form row 0, the rest form row 1
//   result         - window k maximum at result[k*DATA_W +: DATA_W]; holds
//                    its value between completed passes
//   maxpoolingdone - high for the one cycle after result is refreshed
//
// Macro MAX_POOL_SIGNED_EN: when defined, pixels compare as signed values.
// ---------------------------------------------------------------------------
module max_pool
  import max_pool_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_WIN = DEF_NUM_WIN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*NUM_WIN*DATA_W-1:0] indata,
  output logic [NUM_WIN*DATA_W-1:0]   result,
  output logic                        maxpoolingdone
);

  state_t state;
  state_t state_next;

  // Input strip viewed as an array of pixels, element p = pixel p.
  logic [4*NUM_WIN-1:0][DATA_W-1:0] pix;

  // Per window: slot 0 = row0 odd pixel, slot 1 = row1 even, slot 2 = row1 odd.
  logic [NUM_WIN-1:0][SLOTS-1:0][DATA_W-1:0] data_q;

  logic [NUM_WIN-1:0][DATA_W-1:0] acc;
  logic [NUM_WIN-1:0][DATA_W-1:0] cmp_b;
  logic [NUM_WIN-1:0][DATA_W-1:0] cmp_y;

  assign pix = indata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Fixed five-step cycle; there is no start input, the block always runs.
  always_comb begin
    state_next = ST_LOAD;
    case (state)
      ST_LOAD: state_next = ST_CMP1;
      ST_CMP1: state_next = ST_CMP2;
      ST_CMP2: state_next = ST_CMP3;
      ST_CMP3: state_next = ST_DONE;
      ST_DONE: state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  // Pick which held pixel each comparator sees in the current compare step.
  always_comb begin
    cmp_b = '0;
    for (int k = 0; k < NUM_WIN; k++) begin
      case (state)
        ST_CMP2: cmp_b[k] = data_q[k][1];
        ST_CMP3: cmp_b[k] = data_q[k][2];
        default: cmp_b[k] = data_q[k][0];
      endcase
    end
  end

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    max_pool_cmp #(
      .DATA_W(DATA_W)
    ) u_cmp (
      .a(acc[k]),
      .b(cmp_b[k]),
      .y(cmp_y[k])
    );
  end

  // Datapath: capture the strip and seed the accumulators on LOAD, fold in
  // one pixel per window on each compare step, publish on DONE. Data is
  // sampled only on the LOAD edge, so later indata changes wait for the
  // next pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q         <= '0;
      acc            <= '0;
      result         <= '0;
      maxpoolingdone <= 1'b0;
    end else begin
      maxpoolingdone <= 1'b0;
      case (state)
        ST_LOAD: begin
          for (int k = 0; k < NUM_WIN; k++) begin
            acc[k]       <= pix[2*k];
            data_q[k][0] <= pix[2*k+1];
            data_q[k][1] <= pix[2*NUM_WIN+2*k];
            data_q[k][2] <= pix[2*NUM_WIN+2*k+1];
          end
        end
        ST_CMP1, ST_CMP2, ST_CMP3: begin
          acc <= cmp_y;
        end
        ST_DONE: begin
          result         <= acc;
          maxpoolingdone <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool.sv
// ---------------------------------------------------------------------------
// tb_max_pool
// Self-checking bench for max_pool. A reference model derives the expected
// outputs from the pass rules (capture on every fifth edge after reset, the
// maxima appear four edges later) and a compare process checks the DUT on
// every falling edge. Directed passes pin the model with hand-computed
// values; a randomized phase follows.
//
// Macro MAX_POOL_SIGNED_EN: when defined, the model compares signed pixels.
// ---------------------------------------------------------------------------
module tb_max_pool;
  import max_pool_pkg::*;

  localparam int DW   = DEF_DATA_W;
  localparam int NW   = DEF_NUM_WIN;
  localparam int NPIX = 4 * NW;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  indata;
  logic [OUT_W-1:0] result;
  logic             maxpoolingdone;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  max_pool dut (
    .clk(clk),
    .rst(rst),
    .indata(indata),
    .result(result),
    .maxpoolingdone(maxpoolingdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Numeric value of a pixel under the configured comparison.
  function automatic int pixVal(input logic [DW-1:0] p);
`ifdef MAX_POOL_SIGNED_EN
    return int'($signed(p));
`else
    return int'(p);
`endif
  endfunction

  // Reference: for each window, pick the largest of its four pixels.
  function automatic logic [OUT_W-1:0] poolRef(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    logic [DW-1:0]    c [4];
    logic [DW-1:0]    best;
    r = '0;
    for (int k = 0; k < NW; k++) begin
      c[0] = d[(2*k)*DW +: DW];
      c[1] = d[(2*k+1)*DW +: DW];
      c[2] = d[(2*NW+2*k)*DW +: DW];
      c[3] = d[(2*NW+2*k+1)*DW +: DW];
      best = c[0];
      for (int i = 1; i < 4; i++) begin
        if (pixVal(c[i]) > pixVal(best)) best = c[i];
      end
      r[k*DW +: DW] = best;
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] mkUniform(input logic [DW-1:0] v);
    logic [IN_W-1:0] d;
    for (int p = 0; p < NPIX; p++) d[p*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [IN_W-1:0] mkRamp();
    logic [IN_W-1:0] d;
    for (int p = 0; p < NPIX; p++) d[p*DW +: DW] = DW'(p + 1);
    return d;
  endfunction

  function automatic logic [IN_W-1:0] mkSignEdge();
    logic [IN_W-1:0] d;
    d = '0;
    d[0*DW +: DW] = 8'h80;
    d[1*DW +: DW] = 8'h7F;
    d[6*DW +: DW] = 8'h01;
    d[7*DW +: DW] = 8'h00;
    return d;
  endfunction

  function automatic logic [DW-1:0] rndPix();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return {1'b0, {(DW-1){1'b1}}};
      2:       return {1'b1, {(DW-1){1'b0}}};
      3:       return '1;
      default: return DW'($urandom);
    endcase
  endfunction

  // Reference model: edge n after reset captures when n%5==1 and publishes
  // the maxima of that capture when n%5==0.
  int               edgeCnt   = 0;
  logic [IN_W-1:0]  capData   = '0;
  logic [OUT_W-1:0] expResult = '0;
  logic             expDone   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edgeCnt   <= 0;
      capData   <= '0;
      expResult <= '0;
      expDone   <= 1'b0;
    end else begin
      edgeCnt <= edgeCnt + 1;
      if ((edgeCnt + 1) % 5 == 1) capData <= indata;
      if ((edgeCnt + 1) % 5 == 0) begin
        expResult <= poolRef(capData);
        expDone   <= 1'b1;
      end else begin
        expDone <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [IN_W-1:0] d);
    indata = d;
  endtask

  // Count falling edges until the done pulse is seen, bounded.
  task automatic waitDone(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!maxpoolingdone && cyc < 20);
    if (!maxpoolingdone) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL done_timeout: got no pulse in %0d cycles, required one", cyc);
    end
  endtask

  // Run one full pass of a pattern starting just after a done pulse.
  task automatic runLiteral(input string name, input logic [IN_W-1:0] d,
                            input logic [OUT_W-1:0] exp);
    int cyc;
    applyStimulus(d);
    waitDone(cyc);
    checkOutput({name, "_latency"}, cyc, 5);
    checkOutput(name, result, exp);
    checkOutput({name, "_model"}, expResult, exp);
  endtask

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("result", result, expResult);
      checkOutput("done", maxpoolingdone, expDone);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [IN_W-1:0] d;

    rst = 1'b1;
    applyStimulus(mkUniform(8'h03));
    repeat (2) @(negedge clk);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_done", maxpoolingdone, 0);
    checkEn = 1'b1;

    // First pass after reset, then the steady five-cycle period.
    rst = 1'b0;
    waitDone(cyc);
    checkOutput("first_latency", cyc, 5);
    checkOutput("uniform3", result, 24'h030303);
    checkOutput("uniform3_model", expResult, 24'h030303);
    waitDone(cyc);
    checkOutput("period", cyc, 5);

    runLiteral("ramp", mkRamp(), 24'h0C0A08);
`ifdef MAX_POOL_SIGNED_EN
    runLiteral("sign_edge", mkSignEdge(), 24'h00007F);
`else
    runLiteral("sign_edge", mkSignEdge(), 24'h000080);
`endif
    runLiteral("all_ff", mkUniform(8'hFF), 24'hFFFFFF);
    runLiteral("all_00", mkUniform(8'h00), 24'h000000);
    runLiteral("ramp_again", mkRamp(), 24'h0C0A08);

    // New data during CMP2 belongs to the next pass.
    applyStimulus(mkUniform(8'h21));
    repeat (2) @(negedge clk);
    applyStimulus(mkUniform(8'h55));
    waitDone(cyc);
    checkOutput("late_change_old", result, 24'h212121);
    waitDone(cyc);
    checkOutput("late_change_new", result, 24'h555555);

    // Reset during CMP2 clears outputs at once and restarts the latency.
    applyStimulus(mkUniform(8'h66));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_result", result, 0);
    checkOutput("midreset_done", maxpoolingdone, 0);
    @(negedge clk);
    rst = 1'b0;
    waitDone(cyc);
    checkOutput("midreset_latency", cyc, 5);
    checkOutput("midreset_pass", result, 24'h666666);

    // Randomized stimulus; the compare process checks every cycle.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        for (int p = 0; p < NPIX; p++) d[p*DW +: DW] = rndPix();
        applyStimulus(d);
      end
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
